// File: rtl/mac_result_collector_pkg.sv
// Shared definitions for the MAC result collector and its round-robin picker.
// Holds the collector state encoding, counter sizing and result-slice indexing.
package nnfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One extra bit so a full 2^ADDR_WIDTH result count is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int res_slice_lo(input int idx, input int data_width);
        return idx * data_width;
    endfunction

endpackage

// File: rtl/mac_result_collector_if.sv
// Bundles the control, MAC result and result-buffer write signals of the collector.
// The collector uses the master modport; the surrounding fabric uses slave.
interface mac_result_collector_if
    import nnfc_pkg::*;
#(
    parameter int NUM_MACS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                                 start;
    logic [ADDR_WIDTH-1:0]                base_addr;
    logic [count_width(ADDR_WIDTH)-1:0]   num_results;
    logic [NUM_MACS-1:0]                  res_valid;
    logic [NUM_MACS*DATA_WIDTH-1:0]       res_data;
    logic [NUM_MACS-1:0]                  res_ack;
    logic                                 wb_en;
    logic [ADDR_WIDTH-1:0]                wb_addr;
    logic [DATA_WIDTH-1:0]                wb_data;
    logic                                 wb_ready;
    logic                                 busy;
    logic                                 all_done;

    modport master (
        input  start, base_addr, num_results, res_valid, res_data, wb_ready,
        output res_ack, wb_en, wb_addr, wb_data, busy, all_done
    );

    modport slave (
        output start, base_addr, num_results, res_valid, res_data, wb_ready,
        input  res_ack, wb_en, wb_addr, wb_data, busy, all_done
    );

endinterface

// File: rtl/mac_result_collector_rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Kept standalone so the operand-fetch path can reuse it.
module rr_grant #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (enable && !any_grant && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Drains MAC results round-robin onto one result-buffer write port at
// consecutive addresses, flagging all_done once every result is accepted.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start, nothing collected since reset
// ST_RUN   | granting MAC results into the write slot
// ST_DRAIN | all results granted, waiting for the final write accept
// ST_DONE  | every programmed result accepted; all_done held until start
module mac_result_collector
    import nnfc_pkg::*;
#(
    parameter int NUM_MACS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_result_collector_if.master bus
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam int PW = $clog2(NUM_MACS);

    state_t                state, state_nx;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         ptr_nx;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         written;
    logic [CW-1:0]         num_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  wb_en_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;

    logic                  slot_free;
    logic                  accept;
    logic                  start_take;
    logic                  grant_en;
    logic                  any_grant;
    logic [NUM_MACS-1:0]   grant;
    logic [PW-1:0]         grant_idx;
    logic                  busy_c;
    logic                  all_done_c;

    assign slot_free  = !wb_en_q || bus.wb_ready;
    assign accept     = wb_en_q && bus.wb_ready;
    assign start_take = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign grant_en   = (state == ST_RUN) && slot_free && (issued < num_q);

    rr_grant #(.N(NUM_MACS)) u_rr_grant (
        .req       (bus.res_valid),
        .ptr       (rr_ptr),
        .enable    (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Next search starts just past the winner so every MAC gets a turn.
    always_comb begin
        ptr_nx = grant_idx + PW'(1);
        if (int'(grant_idx) == NUM_MACS - 1) begin
            ptr_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy_c     = 1'b0;
        all_done_c = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                all_done_c = (state == ST_DONE);
                if (bus.start) begin
                    state_nx = (bus.num_results == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                if (any_grant && (issued + CW'(1) == num_q)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_c = 1'b1;
                if (accept && (written + CW'(1) == num_q)) begin
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            num_q     <= '0;
            issued    <= '0;
            written   <= '0;
            rr_ptr    <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            if (start_take) begin
                base_q  <= bus.base_addr;
                num_q   <= bus.num_results;
                issued  <= '0;
                written <= '0;
            end else begin
                if (any_grant) begin
                    issued <= issued + CW'(1);
                end
                if (accept) begin
                    written <= written + CW'(1);
                end
            end

            // A grant refills the slot; an accept without a grant empties it;
            // otherwise the slot holds, which also covers the stall case.
            if (any_grant) begin
                wb_en_q   <= 1'b1;
                wb_addr_q <= base_q + issued[ADDR_WIDTH-1:0];
                wb_data_q <= bus.res_data[res_slice_lo(int'(grant_idx), DATA_WIDTH) +: DATA_WIDTH];
                rr_ptr    <= ptr_nx;
            end else if (accept) begin
                wb_en_q <= 1'b0;
            end
        end
    end

    assign bus.res_ack  = grant;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.busy     = busy_c;
    assign bus.all_done = all_done_c;

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: reference model with a
// write scoreboard, driven from a job table plus reset and restart sequences.
module tb_mac_result_collector;
    import nnfc_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_result_collector_if #(.NUM_MACS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mac_result_collector #(.NUM_MACS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  num;
        logic [3:0]  mask;
        int          stall_start;
        int          stall_len;
        int          drain_hold;
        int          restart_at;
        int          exp_writes;
        logic [7:0]  exp_last_addr;
        int          exp_order_n;
        logic [31:0] exp_order;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int     n_vec = 0;
    int     n_err = 0;

    state_t m_state;
    int     m_ptr, m_issued, m_written, m_num, m_base;
    bit     m_wb_en;
    wr_t    sb[$];
    int     mac_seq[N];

    int         obs_writes;
    logic [7:0] obs_last_addr;
    int         obs_order[$];

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] mac_word(input int i);
        return 16'((i << 12) | (mac_seq[i] & 12'hFFF));
    endfunction

    task automatic model_reset();
        m_state   = ST_IDLE;
        m_ptr     = 0;
        m_issued  = 0;
        m_written = 0;
        m_num     = 0;
        m_base    = 0;
        m_wb_en   = 1'b0;
        sb.delete();
    endtask

    task automatic cycle(input logic st, input logic [7:0] base, input logic [8:0] num,
                         input logic rdy, input logic [3:0] mask);
        logic [3:0] exp_ack;
        int         g;
        bit         acc;
        @(negedge clk);
        bus.start       = st;
        bus.base_addr   = base;
        bus.num_results = num;
        bus.wb_ready    = rdy;
        bus.res_valid   = mask;
        for (int i = 0; i < N; i++) bus.res_data[i*DW +: DW] = mac_word(i);
        #1;
        exp_ack = '0;
        g = -1;
        if (m_state == ST_RUN && (!m_wb_en || rdy) && m_issued < m_num) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && mask[j]) g = j;
            end
        end
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("res_ack", 32'(bus.res_ack), 32'(exp_ack));
        chk("busy", 32'(bus.busy), 32'(m_state == ST_RUN || m_state == ST_DRAIN));
        chk("all_done", 32'(bus.all_done), 32'(m_state == ST_DONE));
        chk("wb_en", 32'(bus.wb_en), 32'(m_wb_en));
        if (m_wb_en) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'(bus.wb_en), 32'd0);
            end else begin
                chk("wb_addr", 32'(bus.wb_addr), 32'(sb[0].addr));
                chk("wb_data", 32'(bus.wb_data), 32'(sb[0].data));
            end
        end
        for (int i = 0; i < N; i++) if (bus.res_ack[i]) obs_order.push_back(i);
        if (bus.wb_en && rdy) begin
            obs_writes++;
            obs_last_addr = bus.wb_addr;
        end

        acc = m_wb_en && rdy;
        if (acc) begin
            m_written++;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        if (g >= 0) begin
            sb.push_back('{addr: 8'(m_base + m_issued), data: mac_word(g)});
            m_issued++;
            m_ptr   = (g + 1) % N;
            m_wb_en = 1'b1;
            mac_seq[g]++;
        end else if (acc) begin
            m_wb_en = 1'b0;
        end
        case (m_state)
            ST_IDLE, ST_DONE: if (st) begin
                m_base    = int'(base);
                m_num     = int'(num);
                m_issued  = 0;
                m_written = 0;
                m_state   = (num == 0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (g >= 0 && m_issued == m_num) m_state = ST_DRAIN;
            ST_DRAIN: if (acc && m_written == m_num) m_state = ST_DONE;
            default:  m_state = ST_IDLE;
        endcase
        @(posedge clk);
    endtask

    task automatic run_job(input vec_t v);
        int   cyc;
        int   hold;
        logic rdy;
        logic st;
        obs_writes    = 0;
        obs_last_addr = '0;
        obs_order.delete();
        hold = v.drain_hold;
        cycle(1'b1, v.base, v.num, 1'b1, v.mask);
        cyc = 1;
        while (m_state != ST_DONE && cyc < 2000) begin
            rdy = !(cyc >= v.stall_start && cyc < v.stall_start + v.stall_len);
            if (m_state == ST_DRAIN && hold > 0) begin
                rdy = 1'b0;
                hold--;
            end
            st = (cyc == v.restart_at);
            cycle(st, 8'hAA, 9'd3, rdy, v.mask);
            cyc++;
        end
        if (m_state != ST_DONE) chk("job_timeout", 32'(cyc), 32'd0);
        cycle(1'b0, v.base, v.num, 1'b1, v.mask);
        chk("write_count", 32'(obs_writes), 32'(v.exp_writes));
        if (v.exp_writes > 0) chk("last_addr", 32'(obs_last_addr), 32'(v.exp_last_addr));
        for (int k = 0; k < v.exp_order_n; k++) begin
            if (k < obs_order.size())
                chk("grant_order", 32'(obs_order[k]), 32'(v.exp_order[4*k +: 4]));
            else
                chk("grant_order_missing", 32'(obs_order.size()), 32'(v.exp_order_n));
        end
    endtask

    initial begin
        vec_t clean;
        vecs[0] = '{8'h10, 9'd8,   4'hF, -1, 0, 0, -1, 8,   8'h17, 8, 32'h3210_3210};
        vecs[1] = '{8'h20, 9'd4,   4'hA, -1, 0, 0, -1, 4,   8'h23, 4, 32'h0000_3131};
        vecs[2] = '{8'h30, 9'd10,  4'hF,  4, 3, 0, -1, 10,  8'h39, 0, 32'h0};
        vecs[3] = '{8'hFE, 9'd4,   4'hF, -1, 0, 0, -1, 4,   8'h01, 0, 32'h0};
        vecs[4] = '{8'h55, 9'd0,   4'hF, -1, 0, 0, -1, 0,   8'h00, 0, 32'h0};
        vecs[5] = '{8'h60, 9'd6,   4'h5, -1, 0, 0,  2, 6,   8'h65, 0, 32'h0};
        vecs[6] = '{8'h70, 9'd3,   4'hF, -1, 0, 4, -1, 3,   8'h72, 0, 32'h0};
        vecs[7] = '{8'h00, 9'd256, 4'hF, -1, 0, 0, -1, 256, 8'hFF, 0, 32'h0};

        for (int i = 0; i < N; i++) mac_seq[i] = 0;
        model_reset();
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.num_results = '0;
        bus.res_valid   = '0;
        bus.res_data    = '0;
        bus.wb_ready    = 1'b1;
        #12;
        chk("rst_wb_en",    32'(bus.wb_en),    32'd0);
        chk("rst_wb_addr",  32'(bus.wb_addr),  32'd0);
        chk("rst_wb_data",  32'(bus.wb_data),  32'd0);
        chk("rst_res_ack",  32'(bus.res_ack),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_all_done", 32'(bus.all_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_job(vecs[v]);

        // Reset asserted between edges while a job is mid-flight.
        cycle(1'b1, 8'h40, 9'd6, 1'b1, 4'hF);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h40, 9'd6, 1'b1, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wb_en",    32'(bus.wb_en),    32'd0);
        chk("midrst_wb_addr",  32'(bus.wb_addr),  32'd0);
        chk("midrst_wb_data",  32'(bus.wb_data),  32'd0);
        chk("midrst_res_ack",  32'(bus.res_ack),  32'd0);
        chk("midrst_busy",     32'(bus.busy),     32'd0);
        chk("midrst_all_done", 32'(bus.all_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        clean = '{8'h80, 9'd5, 4'hF, -1, 0, 0, -1, 5, 8'h84, 5, 32'h0000_3210 | (32'h0 << 16)};
        run_job(clean);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t: got running, expected finished", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
Drains accumulated results from NUM_MACS MAC units onto one shared result-buffer write port. Requesters are served round-robin. Writes go to consecutive addresses from a base latched at start. It is the write-back counterpart of the operand fetch/distribution arbiter. It asserts all_done once the programmed number of results has been accepted downstream.

Parameters:
NUM_MACS, 4, number of MAC result requesters (>=2)
ADDR_WIDTH, 8, result-buffer address width
DATA_WIDTH, 16, width of one MAC result

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latches base_addr and num_results, begins collection
base_addr  in  ADDR_WIDTH  first write address
num_results  in  ADDR_WIDTH+1  results to collect, 0..2^ADDR_WIDTH
res_valid  in  NUM_MACS  bit i: MAC i holds a result
res_data  in  NUM_MACS*DATA_WIDTH  MAC i result in slice [i*DATA_WIDTH +: DATA_WIDTH]
res_ack  out  NUM_MACS  combinational one-hot grant; a transfer occurs on the edge where res_valid[i]&res_ack[i]
wb_en  out  1  registered write strobe to result buffer
wb_addr  out  ADDR_WIDTH  registered write address
wb_data  out  DATA_WIDTH  registered write data
wb_ready  in  1  buffer accepts the write on the edge where wb_en&wb_ready
busy  out  1  high in RUN and DRAIN
all_done  out  1  level; high in DONE until the next start

Behaviour:
- Reset (async): state=IDLE; wb_en=0, wb_addr=0, wb_data=0, res_ack=0, busy=0, all_done=0; rr_ptr=0, issued=0, written=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch base_addr and num_results; clear issued, written and all_done.
  - num_results==0: go to DONE.
  - Otherwise go to RUN. rr_ptr is not reset by start.
- start while in RUN or DRAIN: ignored.
- Output slot free: slot_free = !wb_en | wb_ready.
- Grant (RUN only, slot_free, issued<num_results): pick the first i with res_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_MACS. res_ack is one-hot on i, otherwise all zero.
- res_ack is zero in IDLE, DRAIN and DONE, and whenever the slot is stalled.
- On a grant edge:
  - wb_en<=1, wb_data<=res_data slice i, wb_addr<=base+issued (mod 2^ADDR_WIDTH, wraps silently).
  - issued++; rr_ptr<=(i+1) mod NUM_MACS.
- On the edge where wb_en&wb_ready with no new grant: wb_en<=0; wb_addr and wb_data hold.
- On the edge where wb_en&!wb_ready: wb_en, wb_addr and wb_data hold unchanged (stall).
- written increments on each edge where wb_en&wb_ready.
- Throughput: one result per cycle when wb_ready is held high. Latency from grant edge to wb_en high is 1 cycle.
- Transitions:
  - RUN->DRAIN on the grant that makes issued==num_results.
  - DRAIN->DONE on the edge where written reaches num_results, i.e. the last write is accepted.
  - DONE: wb_en=0, all_done=1, busy=0.
- Requester protocol: res_valid and res_data are held until acked. Valid dropping without an ack is legal; that requester is simply skipped.
- Counters issued and written are ADDR_WIDTH+1 bits, so num_results=2^ADDR_WIDTH is exact.
- Reset mid-operation: immediate return to reset values. Any pending write is discarded.

Decomposition:
- Shared package nnfc_pkg: FSM state enum (2 bits), COUNT_WIDTH=ADDR_WIDTH+1 helper, and the res_data slice-index function.
- Sub-module rr_grant: combinational round-robin picker.
  - Inputs: req[NUM_MACS], ptr[$clog2(NUM_MACS)], enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Reused later by the operand-fetch path.

Test Plan:
- Fairness: NUM_MACS=4, all res_valid high, wb_ready=1, num_results=8, base=0x10 -> acks 0,1,2,3,0,1,2,3. wb_addr 0x10..0x17 on consecutive cycles. all_done high one cycle after the last write.
- Skip: only MACs 1 and 3 valid, rr_ptr=0, num_results=4 -> grant order 1,3,1,3. No ack on MACs 0 or 2.
- Backpressure: wb_ready low 3 cycles mid-stream -> wb_en, wb_addr and wb_data frozen; res_ack=0 during the stall. No lost or duplicated data; written count is exact.
- Boundaries:
  - num_results=0 -> DONE the cycle after start, with no wb_en.
  - base=0xFE, num_results=4 -> addresses FE, FF, 00, 01.
  - num_results=256 -> exactly 256 writes.
- Start while busy is ignored. Async rst asserted mid-RUN between clock edges -> outputs zero immediately. A subsequent start runs cleanly.
- Last result with wb_ready low -> state stays in DRAIN, busy=1, all_done=0 until wb_ready rises. DONE follows on the next edge.
